// File: rtl/shift_sequencer_pkg.sv
// Shared constants and FSM state encoding for the shift sequencer.
package shift_sequencer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/shifter1b.sv
// Single-position left shifter: zero fill at bit0, MSB comes out as carry.
module shifter1b #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    assign y     = {a[WIDTH-2:0], 1'b0};
    assign carry = a[WIDTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit position per cycle, fixed latency of N+1
// cycles from acceptance to DONE. All outputs come straight from flops.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             DIR,
    input  logic             ARITH,
    input  logic [WIDTH-1:0] A,
    input  logic [CNT_W-1:0] N,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY
);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [CNT_W-1:0]   cnt;
    logic               dir_q;
    logic               arith_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   left_y;
    logic               left_c;
    logic               fill;

    // Left path uses the shared one-bit shifter
    shifter1b #(.WIDTH(WIDTH)) u_left (
        .a     (work),
        .y     (left_y),
        .carry (left_c)
    );

    // Right path fill bit: sign bit for arithmetic, zero for logical
    assign fill = arith_q & work[WIDTH-1];

    // Control FSM plus datapath; BUSY/DONE registered alongside the state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            work    <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        work    <= A;
                        cnt     <= N;
                        dir_q   <= DIR;
                        arith_q <= ARITH;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (N == '0) begin
                            // Nothing to shift: go straight to the done cycle
                            state  <= ST_FINISH;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (dir_q) begin
                        work    <= {fill, work[WIDTH-1:1]};
                        carry_q <= work[0];
                    end else begin
                        work    <= left_y;
                        carry_q <= left_c;
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_FINISH;
                        done_q <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    // START is deliberately ignored here; requester retries
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = work;
    assign CARRY  = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expectations.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dir;
    logic        arith;
    logic [15:0] a;
    logic [3:0]  n;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;

    int total;
    int bad;

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .DIR    (dir),
        .ARITH  (arith),
        .A      (a),
        .N      (n),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result),
        .CARRY  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch 40 cycles. Cycle 1 is the cycle right
    // after the acceptance edge. Optionally re-raise START (A=FFFF) in
    // cycle restart_at to probe that busy-time requests are dropped.
    task automatic run_op(input logic [15:0] av, input logic [3:0] nv,
                          input logic dv, input logic arv, input int restart_at,
                          output int done_at, output int busy_cnt, output int ndone,
                          output logic [15:0] res, output logic cy);
        @(negedge clk);
        a = av; n = nv; dir = dv; arith = arv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble operands after acceptance; they must not matter
        a = 16'hDEAD; n = 4'd3; dir = ~dv; arith = ~arv;
        done_at = -1; busy_cnt = 0; ndone = 0; res = 16'hxxxx; cy = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
                res = result;
                cy  = carry;
            end
            if (k == restart_at) begin
                start = 1'b1;
                a     = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    int          d_at, b_cnt, nd;
    logic [15:0] r;
    logic        c;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; dir = 1'b0; arith = 1'b0; a = '0; n = '0;
        #2;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry",  32'(carry),  32'd0);
        #10 rst = 1'b0;

        // Max amount, left
        run_op(16'h0001, 4'd15, 1'b0, 1'b0, 0, d_at, b_cnt, nd, r, c);
        check("l15_result", 32'(r),     32'h8000);
        check("l15_carry",  32'(c),     32'd0);
        check("l15_doneat", 32'(d_at),  32'd16);
        check("l15_busy",   32'(b_cnt), 32'd16);
        check("l15_ndone",  32'(nd),    32'd1);

        // Single shift, MSB falls out
        run_op(16'h8001, 4'd1, 1'b0, 1'b0, 0, d_at, b_cnt, nd, r, c);
        check("l1_result", 32'(r),    32'h0002);
        check("l1_carry",  32'(c),    32'd1);
        check("l1_doneat", 32'(d_at), 32'd2);

        // Arithmetic vs logical right
        run_op(16'h8000, 4'd4, 1'b1, 1'b1, 0, d_at, b_cnt, nd, r, c);
        check("ra4_result", 32'(r),    32'hF800);
        check("ra4_carry",  32'(c),    32'd0);
        check("ra4_doneat", 32'(d_at), 32'd5);
        run_op(16'h8000, 4'd4, 1'b1, 1'b0, 0, d_at, b_cnt, nd, r, c);
        check("rl4_result", 32'(r),    32'h0800);
        check("rl4_carry",  32'(c),    32'd0);

        // Right-shift carry is the last bit0 discarded
        run_op(16'h00F0, 4'd5, 1'b1, 1'b0, 0, d_at, b_cnt, nd, r, c);
        check("rl5_result", 32'(r), 32'h0007);
        check("rl5_carry",  32'(c), 32'd1);
        run_op(16'h8000, 4'd15, 1'b1, 1'b1, 0, d_at, b_cnt, nd, r, c);
        check("ra15_result", 32'(r), 32'hFFFF);
        check("ra15_carry",  32'(c), 32'd0);

        // N=0, plus a START during FINISH that must be dropped
        run_op(16'h1234, 4'd0, 1'b0, 1'b0, 1, d_at, b_cnt, nd, r, c);
        check("n0_result", 32'(r),     32'h1234);
        check("n0_carry",  32'(c),     32'd0);
        check("n0_doneat", 32'(d_at),  32'd1);
        check("n0_busy",   32'(b_cnt), 32'd1);
        check("n0_ndone",  32'(nd),    32'd1);

        // START mid-operation ignored
        run_op(16'h00FF, 4'd8, 1'b0, 1'b0, 4, d_at, b_cnt, nd, r, c);
        check("mid_result", 32'(r),     32'hFF00);
        check("mid_carry",  32'(c),     32'd0);
        check("mid_ndone",  32'(nd),    32'd1);
        check("mid_doneat", 32'(d_at),  32'd9);
        check("mid_busy",   32'(b_cnt), 32'd9);

        // Reset in the middle of a 10-step left shift
        @(negedge clk);
        a = 16'h0001; n = 4'd10; dir = 1'b0; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_result", 32'(result), 32'h0010);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy),   32'd0);
        check("arst_done",   32'(done),   32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_carry",  32'(carry),  32'd0);
        @(negedge clk); rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("arst_nodone", 32'(nd), 32'd0);

        run_op(16'h0003, 4'd2, 1'b0, 1'b0, 0, d_at, b_cnt, nd, r, c);
        check("post_result", 32'(r),    32'h000C);
        check("post_carry",  32'(c),    32'd0);
        check("post_doneat", 32'(d_at), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data path width.
REQ-002 The block SHALL have parameter CNT_W, default 4, shift-amount width (max amount 2^CNT_W-1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- DIR  input  1  0 = left, 1 = right; sampled with START.
- ARITH  input  1  1 = arithmetic right (sign fill); ignored when DIR=0; sampled with START.
- A  input  WIDTH  operand; sampled with START.
- N  input  CNT_W  shift amount; sampled with START.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle completion pulse.
- RESULT  output  WIDTH  shifted value.
- CARRY  output  1  last bit shifted out.

Function
REQ-004 The block SHALL implement exactly three states: IDLE, SHIFT and FINISH.
REQ-005 In IDLE, START=1 at a rising edge SHALL latch A, N, DIR and ARITH (acceptance edge).
- N=0 goes to FINISH.
- Otherwise the block goes to SHIFT with a counter of N.
REQ-006 Each SHIFT edge SHALL perform exactly one 1-position shift of the working register and decrement the counter.
- When the counter equals 1 at that edge, the next state is FINISH.
REQ-007 The shift rules SHALL be:
- Left: bit0 := 0, discard MSB.
- Logical right: MSB := 0.
- Arithmetic right: MSB := previous MSB.
REQ-008 CARRY SHALL take the bit discarded by each shift: bit WIDTH-1 for left, bit 0 for right.
- CARRY is cleared to 0 at acceptance, so N=0 gives CARRY=0.
REQ-009 FINISH SHALL last exactly one cycle, with DONE=1; the next state is IDLE.
REQ-010 Latency SHALL be fixed: DONE is high in the cycle following edge N+1 counted from the acceptance edge (N=0 gives DONE one cycle after acceptance).
REQ-011 RESULT SHALL equal the working register at all times; it is final and valid while DONE=1.
- RESULT holds until the next acceptance edge.
REQ-012 START while BUSY=1, including during FINISH, SHALL be ignored; there is no queue, and the requester re-asserts after DONE.
REQ-013 A, N, DIR and ARITH changes after acceptance SHALL NOT affect the operation in progress.
REQ-014 N = 2^CNT_W-1 SHALL be supported with no wrap.
- For WIDTH=16 and N=15, left shift leaves only the original bit0 at bit15.
REQ-015 Counter and register arithmetic SHALL be unsigned; the counter never underflows (SHIFT is never entered with count 0).

Reset
REQ-016 RST=1 SHALL asynchronously force the following, regardless of state, including mid-operation:
- State = IDLE.
- BUSY = 0, DONE = 0, CARRY = 0, RESULT = 0.
- Counter = 0.
REQ-017 An operation interrupted by reset SHALL be lost, with no DONE pulse.
REQ-018 The first acceptance SHALL be possible at the first rising edge after RST deasserts.

Structure
REQ-019 The state encodings (IDLE, SHIFT, FINISH) and default WIDTH/CNT_W constants SHALL reside in a shared package/include used by the processor control.
REQ-020 The left-shift path SHALL instantiate the existing single-position left shifter shifter1b as its one sub-module.
- The right (logical/arithmetic) path is inline logic.
- A WIDTH=16 build is required for the shifter1b instance.
REQ-021 Outputs SHALL be registered.
- DONE and BUSY are decoded from registered state only, with no combinational path from inputs.

Verification
REQ-022 A bench SHALL cover at least these directed scenarios:
- A=0x0001, N=15, DIR=0 -> DONE 16 cycles after acceptance, RESULT=0x8000, CARRY=0, BUSY high 16 cycles.
- A=0x8001, N=1, DIR=0 -> RESULT=0x0002, CARRY=1, DONE 2 cycles after acceptance.
- A=0x8000, N=4, DIR=1, ARITH=1 -> RESULT=0xF800, CARRY=0; same with ARITH=0 -> RESULT=0x0800.
- A=0x1234, N=0 -> DONE next cycle, RESULT=0x1234, CARRY=0, BUSY high exactly 1 cycle.
- A=0x00FF, N=8, left; second START with A=0xFFFF mid-operation -> ignored, RESULT=0xFF00, single DONE.
- Left shift with N=10, RST pulsed at cycle 5 -> all outputs 0 immediately, no DONE; a new START after release completes normally.
